// File: rtl/kms_event_decoder.sv
// kms_event_decoder
//   Decodes the toggle-level keyboard/mouse event stream from the HPS I/O
//   block in the clk_sys domain. Mouse movement is accumulated into
//   free-running 8-bit X/Y counters. Keycodes are queued in a first-word
//   fall-through FIFO that the CIA keyboard serialiser drains over a
//   valid/ready handshake.
//
// Parameters
//   FIFO_DEPTH  key FIFO entries, power of two, 2..64
//   Y_INVERT    1: subtract Y movement instead of adding it
//
// Ports
//   clk_sys       in   system clock, rising edge
//   reset_n       in   asynchronous active-low reset
//   kms_level     in   toggles once per new event
//   kms_type      in   0=mouse X, 1=mouse Y, 2=keycode, 3=OSD keycode
//   kms_data      in   movement (two's complement) or keycode
//   mouse_btn_in  in   mouse button state
//   mouse_x/y     out  position counters, wrap modulo 256
//   mouse_btn     out  registered mouse buttons
//   kbd_valid     out  FIFO not empty
//   kbd_data      out  keycode at FIFO head
//   kbd_osd       out  head entry came from an OSD keycode
//   kbd_ready     in   pop head when kbd_valid & kbd_ready
//   kbd_overflow  out  sticky flag, a key event was dropped
//   ovf_clr       in   clears kbd_overflow (a same-cycle drop wins)
//   fifo_level    out  entries held, 0..FIFO_DEPTH
module kms_event_decoder #(
  parameter int FIFO_DEPTH = 8,
  parameter bit Y_INVERT   = 1'b0
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       kms_level,
  input  logic [1:0] kms_type,
  input  logic [7:0] kms_data,
  input  logic [2:0] mouse_btn_in,
  output logic [7:0] mouse_x,
  output logic [7:0] mouse_y,
  output logic [2:0] mouse_btn,
  output logic       kbd_valid,
  output logic [7:0] kbd_data,
  output logic       kbd_osd,
  input  logic       kbd_ready,
  output logic       kbd_overflow,
  input  logic       ovf_clr,
  output logic [6:0] fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);

  // The first edge after reset only captures the current level, so a
  // toggle that was pending while in reset is never reported as an event.
  typedef enum logic {
    ST_UNARMED,
    ST_ARMED
  } arm_state_e;

  arm_state_e      arm_q, arm_d;
  logic            level_q, level_d;
  logic [7:0]      mouse_x_q, mouse_x_d;
  logic [7:0]      mouse_y_q, mouse_y_d;
  logic [2:0]      mouse_btn_q, mouse_btn_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [6:0]      count_q, count_d;
  logic            ovf_q, ovf_d;
  logic [8:0]      mem_q [FIFO_DEPTH];

  logic            evt;
  logic            key_req;
  logic            pop;
  logic            push_ok;
  logic [8:0]      head;

  always_comb begin
    arm_d       = ST_ARMED;
    level_d     = kms_level;
    mouse_x_d   = mouse_x_q;
    mouse_y_d   = mouse_y_q;
    mouse_btn_d = mouse_btn_in;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    ovf_d       = ovf_q;

    evt     = (arm_q == ST_ARMED) && (kms_level != level_q);
    key_req = evt && kms_type[1];
    pop     = (count_q != '0) && kbd_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    push_ok = key_req && ((count_q < 7'(FIFO_DEPTH)) || pop);

    if (evt && (kms_type == 2'd0)) begin
      mouse_x_d = mouse_x_q + kms_data;
    end
    if (evt && (kms_type == 2'd1)) begin
      mouse_y_d = Y_INVERT ? (mouse_y_q - kms_data) : (mouse_y_q + kms_data);
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    count_d = count_q + {6'd0, push_ok} - {6'd0, pop};

    if (key_req && !push_ok) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      arm_q       <= ST_UNARMED;
      level_q     <= 1'b0;
      mouse_x_q   <= '0;
      mouse_y_q   <= '0;
      mouse_btn_q <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
    end else begin
      arm_q       <= arm_d;
      level_q     <= level_d;
      mouse_x_q   <= mouse_x_d;
      mouse_y_q   <= mouse_y_d;
      mouse_btn_q <= mouse_btn_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
    end
  end

  // Storage needs no reset: the head is masked whenever the FIFO is empty.
  always_ff @(posedge clk_sys) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= {(kms_type == 2'd3), kms_data};
    end
  end

  assign head         = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign kbd_valid    = (count_q != '0);
  assign kbd_data     = head[7:0];
  assign kbd_osd      = head[8];
  assign kbd_overflow = ovf_q;
  assign fifo_level   = count_q;
  assign mouse_x      = mouse_x_q;
  assign mouse_y      = mouse_y_q;
  assign mouse_btn    = mouse_btn_q;

endmodule

// File: tb/tb_kms_event_decoder.sv
module tb_kms_event_decoder;

  localparam int DEPTH = 8;

  logic       clk_sys = 1'b0;
  logic       reset_n;
  logic       kms_level;
  logic [1:0] kms_type;
  logic [7:0] kms_data;
  logic [2:0] mouse_btn_in;
  logic       kbd_ready;
  logic       ovf_clr;

  logic [7:0] mouse_x, mouse_y, mouse_y_i;
  logic [2:0] mouse_btn, mouse_btn_i;
  logic       kbd_valid, kbd_osd, kbd_overflow;
  logic       kbd_valid_i, kbd_osd_i, kbd_overflow_i;
  logic [7:0] kbd_data, kbd_data_i, mouse_x_i;
  logic [6:0] fifo_level, fifo_level_i;

  kms_event_decoder #(.FIFO_DEPTH(DEPTH), .Y_INVERT(1'b0)) u_dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .kms_level(kms_level),
    .kms_type(kms_type), .kms_data(kms_data), .mouse_btn_in(mouse_btn_in),
    .mouse_x(mouse_x), .mouse_y(mouse_y), .mouse_btn(mouse_btn),
    .kbd_valid(kbd_valid), .kbd_data(kbd_data), .kbd_osd(kbd_osd),
    .kbd_ready(kbd_ready), .kbd_overflow(kbd_overflow), .ovf_clr(ovf_clr),
    .fifo_level(fifo_level)
  );

  kms_event_decoder #(.FIFO_DEPTH(DEPTH), .Y_INVERT(1'b1)) u_dut_yinv (
    .clk_sys(clk_sys), .reset_n(reset_n), .kms_level(kms_level),
    .kms_type(kms_type), .kms_data(kms_data), .mouse_btn_in(mouse_btn_in),
    .mouse_x(mouse_x_i), .mouse_y(mouse_y_i), .mouse_btn(mouse_btn_i),
    .kbd_valid(kbd_valid_i), .kbd_data(kbd_data_i), .kbd_osd(kbd_osd_i),
    .kbd_ready(kbd_ready), .kbd_overflow(kbd_overflow_i), .ovf_clr(ovf_clr),
    .fifo_level(fifo_level_i)
  );

  always #5 clk_sys = ~clk_sys;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // reference model
  logic [7:0] m_x, m_y, m_yi;
  logic [8:0] m_q[$];
  bit         m_ovf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic check_state(input string where);
    check({where, ":mouse_x"}, 32'(mouse_x), 32'(m_x));
    check({where, ":mouse_y"}, 32'(mouse_y), 32'(m_y));
    check({where, ":mouse_y_inv"}, 32'(mouse_y_i), 32'(m_yi));
    check({where, ":fifo_level"}, 32'(fifo_level), 32'(m_q.size()));
    check({where, ":kbd_valid"}, 32'(kbd_valid), 32'(m_q.size() != 0));
    check({where, ":kbd_overflow"}, 32'(kbd_overflow), 32'(m_ovf));
    if (m_q.size() != 0) begin
      check({where, ":head_data"}, 32'(kbd_data), 32'(m_q[0][7:0]));
      check({where, ":head_osd"}, 32'(kbd_osd), 32'(m_q[0][8]));
    end else begin
      check({where, ":empty_data"}, 32'(kbd_data), 32'h0);
    end
  endtask

  // Drive one event; optionally pop in the same cycle. Popped entries are
  // compared against the scoreboard at the handshake.
  task automatic send(input string where, input logic [1:0] t, input logic [7:0] d,
                      input bit with_pop, input bit clr);
    int unsigned sz;
    bit          popped;
    bit          drop;
    sz     = m_q.size();
    popped = with_pop && (sz != 0);
    if (popped) begin
      check({where, ":pop_data"}, 32'(kbd_data), 32'(m_q[0][7:0]));
      check({where, ":pop_osd"}, 32'(kbd_osd), 32'(m_q[0][8]));
    end
    kbd_ready = with_pop;
    ovf_clr   = clr;
    kms_type  = t;
    kms_data  = d;
    kms_level = ~kms_level;
    tick();
    kbd_ready = 1'b0;
    ovf_clr   = 1'b0;
    drop = 1'b0;
    if (popped) void'(m_q.pop_front());
    case (t)
      2'd0: m_x = m_x + d;
      2'd1: begin m_y = m_y + d; m_yi = m_yi - d; end
      default: begin
        if (sz < DEPTH || popped) m_q.push_back({(t == 2'd3), d});
        else drop = 1'b1;
      end
    endcase
    if (drop) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    check_state(where);
  endtask

  task automatic pop_only(input string where);
    check({where, ":pop_valid"}, 32'(kbd_valid), 32'd1);
    if (m_q.size() != 0) begin
      check({where, ":pop_data"}, 32'(kbd_data), 32'(m_q[0][7:0]));
      check({where, ":pop_osd"}, 32'(kbd_osd), 32'(m_q[0][8]));
    end
    kbd_ready = 1'b1;
    tick();
    kbd_ready = 1'b0;
    if (m_q.size() != 0) void'(m_q.pop_front());
    check_state(where);
  endtask

  // Level is toggled during reset to show a pending toggle is lost.
  task automatic do_reset(input string where);
    reset_n = 1'b0;
    kms_type = 2'd2;
    kms_data = 8'h77;
    tick();
    kms_level = ~kms_level;
    tick();
    reset_n = 1'b1;
    tick();
    m_x = '0; m_y = '0; m_yi = '0; m_ovf = 1'b0;
    m_q.delete();
    check_state(where);
  endtask

  initial begin
    reset_n = 1'b0; kms_level = 1'b1; kms_type = 2'd2; kms_data = 8'h77;
    mouse_btn_in = 3'd0; kbd_ready = 1'b0; ovf_clr = 1'b0;
    m_x = '0; m_y = '0; m_yi = '0; m_ovf = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    check("rst:mouse_x", 32'(mouse_x), 32'h0);
    check("rst:kbd_valid", 32'(kbd_valid), 32'h0);
    check("rst:mouse_btn", 32'(mouse_btn), 32'h0);
    check_state("rst");

    send("mx1", 2'd0, 8'h05, 1'b0, 1'b0);
    check("mx1:const", 32'(mouse_x), 32'h05);
    send("mx2", 2'd0, 8'hFD, 1'b0, 1'b0);
    check("mx2:const", 32'(mouse_x), 32'h02);

    send("my1", 2'd1, 8'hFA, 1'b0, 1'b0);
    check("my1:const", 32'(mouse_y), 32'hFA);
    send("my2", 2'd1, 8'h0A, 1'b0, 1'b0);
    check("my2:wrap", 32'(mouse_y), 32'h04);
    send("my3", 2'd1, 8'hFC, 1'b0, 1'b0);
    check("my3:inv_zero", 32'(mouse_y_i), 32'h00);
    send("my4", 2'd1, 8'h01, 1'b0, 1'b0);
    check("my4:inv_wrap", 32'(mouse_y_i), 32'hFF);

    mouse_btn_in = 3'b101;
    tick();
    check("btn", 32'(mouse_btn), 32'h5);
    check_state("btn_no_event");

    send("k45", 2'd2, 8'h45, 1'b0, 1'b0);
    send("k63", 2'd3, 8'h63, 1'b0, 1'b0);
    check("keys:head", 32'(kbd_data), 32'h45);
    check("keys:level", 32'(fifo_level), 32'd2);
    pop_only("pop1");
    check("pop1:head", 32'(kbd_data), 32'h63);
    check("pop1:osd", 32'(kbd_osd), 32'd1);
    pop_only("pop2");

    kbd_ready = 1'b1;
    tick();
    kbd_ready = 1'b0;
    check_state("ready_empty");

    for (int i = 1; i <= 9; i++) send("ovf_fill", 2'd2, 8'(i), 1'b0, 1'b0);
    check("ovf:level", 32'(fifo_level), 32'd8);
    check("ovf:flag", 32'(kbd_overflow), 32'd1);
    send("ovf_set_clr", 2'd2, 8'h0A, 1'b0, 1'b1);
    check("ovf:set_wins", 32'(kbd_overflow), 32'd1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    m_ovf = 1'b0;
    check_state("ovf_clr");

    send("full_pop_push", 2'd2, 8'hAA, 1'b1, 1'b0);
    check("fpp:level", 32'(fifo_level), 32'd8);
    check("fpp:ovf", 32'(kbd_overflow), 32'd0);
    for (int g = 0; g < 20 && m_q.size() != 0; g++) pop_only("drain");
    check("drain:empty", 32'(kbd_valid), 32'd0);

    send("mid_k", 2'd3, 8'h11, 1'b0, 1'b0);
    send("mid_x", 2'd0, 8'h33, 1'b0, 1'b0);
    do_reset("mid_reset");
    check("mid_reset:valid", 32'(kbd_valid), 32'd0);
    send("post_rst", 2'd2, 8'h5A, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
